multi_button_debounce: RTL and testbench
========================================

// Module: multi_button_debounce
// PURPOSE
//   Debounces N_CH mechanical button/switch inputs in one block on the system clock.
//   No derived clock: a shared prescaler produces a one-cycle tick enable.
//   Per channel it outputs a clean level, press/release strobes and a long-press strobe.
//   Sits between board pins and the control FSM / MMIO input register.
// PARAMETERS
//   N_CH       5       number of button channels
//   CLK_DIV    100000  clk cycles per debounce tick (1 ms at 100 MHz); >=2
//   DELAY      20      ticks an input must differ from the debounced level before that level flips; >=1
//   LONG_TICKS 1000    ticks of continuous debounced press before btn_long fires; 0 disables btn_long
//   INV_MASK   {N_CH{1'b0}}  per-channel bit; 1 = pin is active-low, inverted before the synchroniser
// PORTS
//   clk          in   1     system clock
//   rst          in   1     reset; asynchronous, active-high
//   btn_in       in   N_CH  raw asynchronous button pins
//   btn_level    out  N_CH  debounced level, 1 = pressed
//   btn_press    out  N_CH  one-cycle strobe on debounced 0->1
//   btn_release  out  N_CH  one-cycle strobe on debounced 1->0
//   btn_long     out  N_CH  one-cycle strobe when a press reaches LONG_TICKS ticks
//   tick         out  1     prescaler tick, for reuse by neighbours
// BEHAVIOUR
//   Reset (async assert, sync release): all outputs 0; prescaler, synchronisers, counters and levels 0.
//   Prescaler: div_cnt 0..CLK_DIV-1, wraps to 0; tick=1 only in the cycle div_cnt==CLK_DIV-1.
//     First tick after reset occurs on cycle CLK_DIV.
//   Input path: raw = btn_in ^ INV_MASK, then 2-flop synchroniser per channel -> sync[i].
//   Debounce, per channel i, independent:
//     sync==level: deb_cnt<=0 every clk, regardless of tick.
//     sync!=level and tick: if deb_cnt==DELAY-1 then level<=~level, deb_cnt<=0; else deb_cnt++.
//     sync!=level, no tick: hold.
//     Any single-cycle return to sync==level restarts the count (glitch rejection).
//     Latency: 2 clk (sync) + DELAY ticks of continuous mismatch; flip takes effect on the DELAY-th tick.
//     deb_cnt width $clog2(DELAY+1); never exceeds DELAY-1.
//   Strobes registered alongside level: btn_press[i]=1 in exactly the first cycle btn_level[i]
//     reads 1; btn_release[i]=1 in exactly the first cycle it reads 0. Never both at once.
//   Long press: hold_cnt[i] cleared whenever level[i]==0; while level[i]==1 increments on tick,
//     saturating at LONG_TICKS. btn_long[i] pulses one cycle on the tick hold_cnt reaches
//     LONG_TICKS. Exactly once per press; a new press is required to re-arm.
//     Width $clog2(LONG_TICKS+1). LONG_TICKS==0: btn_long tied 0, hold_cnt unused.
//   Simultaneous: channels fully independent; several strobes may assert in the same cycle.
//   Reset mid-operation: counts discarded, levels to 0; no release strobe emitted for levels held at reset.
// TESTING (CLK_DIV=4, DELAY=3, LONG_TICKS=5, N_CH=2, INV_MASK=2'b10)
//   1 Reset: rst high -> all outputs 0; tick first high on cycle 4 after release, then every 4 cycles.
//   2 btn_in[0]=1 held -> btn_level[0] rises on 3rd tick after sync; btn_press[0] high 1 cycle only.
//   3 btn_in[0] bounces 1,0,1 with a 0 lasting 1 cycle before the 3rd tick -> no flip; count restarts.
//   4 Hold btn_in[0]=1 -> btn_long[0] single pulse 5 ticks after btn_press; none further while held.
//   5 Release after long -> btn_release[0] 3 ticks later; re-press re-arms btn_long.
//   6 Ch1 active-low: btn_in[1]=0 -> btn_level[1]=1; both channels pressed same cycle -> both press
//     strobes coincide; rst asserted mid-count -> levels 0 at once, no strobes.

Source files
------------

// File: rtl/multi_button_debounce.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : multi_button_debounce
// Purpose  : Debounces N_CH mechanical button/switch pins on the system clock.
//            A shared prescaler makes a one-cycle tick enable; each channel
//            has an input inverter (INV_MASK), a 2-flop synchroniser and a
//            tick-based debounce counter. It also produces press/release
//            strobes and a long-press strobe.
// Ports    : clk          in   system clock
//            rst          in   asynchronous, active-high reset
//            btn_in       in   [N_CH] raw asynchronous button pins
//            btn_level    out  [N_CH] debounced level, 1 = pressed
//            btn_press    out  [N_CH] one-cycle strobe on debounced 0->1
//            btn_release  out  [N_CH] one-cycle strobe on debounced 1->0
//            btn_long     out  [N_CH] one-cycle strobe at LONG_TICKS of press
//            tick         out  prescaler tick, reusable by neighbours
// Revision : 1.0  initial release
// ============================================================================
module multi_button_debounce #(
  parameter int              N_CH       = 5,
  parameter int              CLK_DIV    = 100000,
  parameter int              DELAY      = 20,
  parameter int              LONG_TICKS = 1000,
  parameter logic [N_CH-1:0] INV_MASK   = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] btn_press,
  output logic [N_CH-1:0] btn_release,
  output logic [N_CH-1:0] btn_long,
  output logic            tick
);

  localparam int c_div_w = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int c_deb_w = (DELAY > 0) ? $clog2(DELAY + 1) : 1;
  localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CLK_DIV - 1);
  localparam logic [c_deb_w-1:0] c_deb_last = c_deb_w'(DELAY - 1);

  // --------------------------------------------------------------------------
  // Shared prescaler
  // --------------------------------------------------------------------------
  logic [c_div_w-1:0] r_div_cnt;
  logic               w_tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_cnt <= '0;
    end else if (r_div_cnt == c_div_last) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  assign w_tick = (r_div_cnt == c_div_last);
  assign tick   = w_tick;

  // --------------------------------------------------------------------------
  // Polarity normalisation and 2-flop synchroniser (all channels)
  // --------------------------------------------------------------------------
  logic [N_CH-1:0] r_sync_meta;
  logic [N_CH-1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync_meta <= '0;
      r_sync      <= '0;
    end else begin
      r_sync_meta <= btn_in ^ INV_MASK;
      r_sync      <= r_sync_meta;
    end
  end

  // --------------------------------------------------------------------------
  // Per-channel debounce and long-press detection
  // --------------------------------------------------------------------------
  genvar i;
  generate
    for (i = 0; i < N_CH; i++) begin : g_ch
      logic [c_deb_w-1:0] r_deb_cnt;
      logic               r_level;
      logic               r_press;
      logic               r_release;

      // Any cycle with sync equal to level clears the count, so a single
      // cycle glitch back to the current level restarts the whole delay.
      // Strobes are registered in the same edge as the level flip so they
      // line up exactly with the first cycle of the new level.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_deb_cnt <= '0;
          r_level   <= 1'b0;
          r_press   <= 1'b0;
          r_release <= 1'b0;
        end else begin
          r_press   <= 1'b0;
          r_release <= 1'b0;
          if (r_sync[i] == r_level) begin
            r_deb_cnt <= '0;
          end else if (w_tick) begin
            if (r_deb_cnt == c_deb_last) begin
              r_deb_cnt <= '0;
              r_level   <= ~r_level;
              r_press   <= ~r_level;
              r_release <= r_level;
            end else begin
              r_deb_cnt <= r_deb_cnt + 1'b1;
            end
          end
        end
      end

      assign btn_level[i]   = r_level;
      assign btn_press[i]   = r_press;
      assign btn_release[i] = r_release;

      if (LONG_TICKS > 0) begin : g_long_on
        localparam int c_hold_w = $clog2(LONG_TICKS + 1);
        localparam logic [c_hold_w-1:0] c_hold_max = c_hold_w'(LONG_TICKS);

        logic [c_hold_w-1:0] r_hold_cnt;
        logic                r_long;

        // Saturating at LONG_TICKS makes the strobe fire once per press;
        // only a release (which clears the count) re-arms it.
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            r_hold_cnt <= '0;
            r_long     <= 1'b0;
          end else begin
            r_long <= 1'b0;
            if (!r_level) begin
              r_hold_cnt <= '0;
            end else if (w_tick && (r_hold_cnt != c_hold_max)) begin
              r_hold_cnt <= r_hold_cnt + 1'b1;
              if (r_hold_cnt == (c_hold_max - 1'b1)) begin
                r_long <= 1'b1;
              end
            end
          end
        end

        assign btn_long[i] = r_long;
      end else begin : g_long_off
        assign btn_long[i] = 1'b0;
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_multi_button_debounce.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : tb_multi_button_debounce
// Purpose  : Self-checking bench for multi_button_debounce with CLK_DIV=4,
//            DELAY=3, LONG_TICKS=5, N_CH=2, INV_MASK=2'b10. A table of
//            {edge number, pins, expected outputs} drives the main sequence;
//            reset behaviour is checked by hand-written sequences.
//            Edge n is the n-th rising clock edge after reset release; tick
//            reads 1 after edges 3,7,11,... and tick-qualified updates
//            happen on edges 4,8,12,...
// Revision : 1.0  initial release
// ============================================================================
module tb_multi_button_debounce;

  logic       clk;
  logic       rst;
  logic [1:0] btn_in;
  logic [1:0] btn_level;
  logic [1:0] btn_press;
  logic [1:0] btn_release;
  logic [1:0] btn_long;
  logic       tick;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  multi_button_debounce #(
    .N_CH      (2),
    .CLK_DIV   (4),
    .DELAY     (3),
    .LONG_TICKS(5),
    .INV_MASK  (2'b10)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_in     (btn_in),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_long   (btn_long),
    .tick       (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         edge_no;
    logic [1:0] btn;
    logic [1:0] lvl;
    logic [1:0] prs;
    logic [1:0] rel;
    logic [1:0] lng;
    logic       tk;
  } vec_t;

  vec_t vq[$];

  task automatic add(input int e, input logic [1:0] b, input logic [1:0] l,
                     input logic [1:0] p, input logic [1:0] r,
                     input logic [1:0] g, input logic t);
    vec_t v;
    v.edge_no = e; v.btn = b; v.lvl = l; v.prs = p; v.rel = r; v.lng = g; v.tk = t;
    vq.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %b, expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [1:0] l, input logic [1:0] p,
                           input logic [1:0] r, input logic [1:0] g, input logic t);
    check({tag, " level"},   btn_level,      l);
    check({tag, " press"},   btn_press,      p);
    check({tag, " release"}, btn_release,    r);
    check({tag, " long"},    btn_long,       g);
    check({tag, " tick"},    {1'b0, tick},   {1'b0, t});
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Pins at rest: ch0 active-high low, ch1 active-low high.
    rst    = 1'b1;
    btn_in = 2'b10;

    // ---- Reset state ----
    repeat (3) @(posedge clk);
    #1;
    check_all("reset", 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
    rst = 1'b0;
    cyc = 0;

    // ---- Table: press, glitch, long, release, re-press, channel 1 ----
    //   edge  pins   level  press  rel    long   tick
    add(  2, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
    add(  3, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1); // first tick
    add(  4, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
    add(  7, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1);
    add(  8, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0); // ch0 pressed
    add( 16, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0); // count at 2
    add( 17, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0); // one-cycle bounce
    add( 20, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0); // no flip: restarted
    add( 27, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1);
    add( 28, 2'b11, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0); // level up + press
    add( 29, 2'b11, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0);
    add( 47, 2'b11, 2'b01, 2'b00, 2'b00, 2'b00, 1'b1);
    add( 48, 2'b11, 2'b01, 2'b00, 2'b00, 2'b01, 1'b0); // long press
    add( 49, 2'b11, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0);
    add( 80, 2'b11, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0); // no repeat long
    add( 91, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 1'b1); // ch0 released
    add( 92, 2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0); // release strobe
    add( 93, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
    add(103, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1); // re-press
    add(104, 2'b11, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0);
    add(123, 2'b11, 2'b01, 2'b00, 2'b00, 2'b00, 1'b1);
    add(124, 2'b11, 2'b01, 2'b00, 2'b00, 2'b01, 1'b0); // long re-armed
    add(125, 2'b11, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0);
    add(136, 2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0);
    add(147, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1); // ch1 pin low
    add(148, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 1'b0); // ch1 pressed
    add(160, 2'b10, 2'b00, 2'b00, 2'b10, 2'b00, 1'b0); // ch1 released
    add(172, 2'b01, 2'b11, 2'b11, 2'b00, 2'b00, 1'b0); // both at once
    add(173, 2'b01, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0);
    add(181, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0); // release mid-count

    foreach (vq[k]) begin
      btn_in = vq[k].btn;
      if (vq[k].edge_no <= cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL table order at entry %0d: edge %0d already passed", k, vq[k].edge_no);
      end
      while (cyc < vq[k].edge_no) step();
      check_all($sformatf("vec%0d", k), vq[k].lvl, vq[k].prs, vq[k].rel, vq[k].lng, vq[k].tk);
    end

    // ---- Reset mid-count: async clear, no release strobes ----
    rst = 1'b1;
    #1;
    check_all("async rst", 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
    step();
    check_all("rst held", 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
    rst = 1'b0;
    cyc = 0;
    step();
    step();
    check_all("post rst e2", 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
    step();
    check_all("post rst e3", 2'b00, 2'b00, 2'b00, 2'b00, 1'b1);
    repeat (6) step();
    check_all("post rst e9", 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
